// File: rtl/btn_switch_capture.sv
`timescale 1ns/1ps
// Debounced button capture of a 24-bit switch bank, exposed to the CPU as a small MMIO
// read port (data / status / press count). FSM state is visible on dbg_state.
module btn_switch_capture #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic        fpga_clk,
  input  logic        fpga_rst,
  input  logic        ck_btn,
  input  logic [23:0] switch2N4,
  input  logic        rd_en,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        data_valid,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    CAPTURE  = 3'd2,
    HELD     = 3'd3,
    REL_DB   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             btn_m, btn_s;
  logic [23:0]      sw_m, sw_s;
  logic [23:0]      cap_reg;
  logic [7:0]       press_cnt;
  logic             overrun;
  logic             capture;
  logic             clr_dv;
  logic             clr_ov;

  // Handshake: rd_en is a single-cycle strobe with no backpressure; rd_data for that
  // access is valid from the following edge and holds until the next strobe.
  assign capture   = (state == CAPTURE);
  assign clr_dv    = rd_en && (rd_addr == 2'd0);
  assign clr_ov    = rd_en && (rd_addr == 2'd1);
  assign dbg_state = state;

  always_ff @(posedge fpga_clk or posedge fpga_rst) begin
    if (fpga_rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      sw_m  <= '0;
      sw_s  <= '0;
    end else begin
      btn_m <= ck_btn;
      btn_s <= btn_m;
      sw_m  <= switch2N4;
      sw_s  <= sw_m;
    end
  end

  always_ff @(posedge fpga_clk or posedge fpga_rst) begin
    if (fpga_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (btn_s) begin
            state <= PRESS_DB;
            cnt   <= CNT_W'(1);
          end
        end
        PRESS_DB: begin
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= CAPTURE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CAPTURE: begin
          state <= HELD;
          cnt   <= '0;
        end
        HELD: begin
          // Only a debounced release re-arms; holding never recaptures.
          if (!btn_s) begin
            state <= REL_DB;
            cnt   <= CNT_W'(1);
          end
        end
        REL_DB: begin
          if (btn_s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // A capture beats a same-edge clear; a data read on the capture edge consumes the
  // old word, so it does not count as an overrun.
  always_ff @(posedge fpga_clk or posedge fpga_rst) begin
    if (fpga_rst) begin
      cap_reg    <= '0;
      press_cnt  <= '0;
      overrun    <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      if (capture) begin
        cap_reg    <= sw_s;
        press_cnt  <= press_cnt + 8'd1;
        data_valid <= 1'b1;
        if (data_valid && !clr_dv) begin
          overrun <= 1'b1;
        end else if (clr_ov) begin
          overrun <= 1'b0;
        end
      end else begin
        if (clr_dv) data_valid <= 1'b0;
        if (clr_ov) overrun    <= 1'b0;
      end
    end
  end

  always_ff @(posedge fpga_clk or posedge fpga_rst) begin
    if (fpga_rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      case (rd_addr)
        2'd0:    rd_data <= {8'h00, cap_reg};
        2'd1:    rd_data <= {30'b0, overrun, data_valid};
        2'd2:    rd_data <= {24'b0, press_cnt};
        default: rd_data <= 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_switch_capture.sv
`timescale 1ns/1ps
// Bench for btn_switch_capture: directed scenarios, a vector table and a random run,
// all scored against a run-length model of the debounce rules.
module tb_btn_switch_capture;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn;
  logic [23:0] sw;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic        data_valid;
  logic [2:0]  dbg_state;

  btn_switch_capture #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .fpga_clk   (clk),
    .fpga_rst   (rst),
    .ck_btn     (btn),
    .switch2N4  (sw),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .data_valid (data_valid),
    .dbg_state  (dbg_state)
  );

  always #1 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Reference model: level seen by the debouncer lags the pin by two edges; a press is
  // accepted after D consecutive high samples, a release after D consecutive lows.
  localparam int PH_WAIT_HIGH = 0, PH_CAP = 1, PH_WAIT_LOW = 2;
  int          m_phase, m_run;
  logic        m_b1, m_b2, m_dv, m_ov;
  logic [23:0] m_s1, m_s2, m_cap;
  logic [7:0]  m_cnt;
  logic [31:0] m_rd;

  logic        b_cur;
  logic [23:0] s_cur;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_phase = PH_WAIT_HIGH; m_run = 0;
    m_b1 = 0; m_b2 = 0; m_s1 = '0; m_s2 = '0;
    m_dv = 0; m_ov = 0; m_cap = '0; m_cnt = '0; m_rd = '0;
  endfunction

  function automatic void model_edge(input logic b, input logic [23:0] s, input logic re,
                                     input logic [1:0] a);
    logic        seen_b;
    logic [23:0] seen_s;
    logic [31:0] rv;
    seen_b = m_b2; seen_s = m_s2;
    m_b2 = m_b1; m_b1 = b; m_s2 = m_s1; m_s1 = s;
    if (re) begin
      case (a)
        2'd0:    rv = {8'h00, m_cap};
        2'd1:    rv = {30'b0, m_ov, m_dv};
        2'd2:    rv = {24'b0, m_cnt};
        default: rv = 32'h0;
      endcase
      exp_q.push_back(rv);
      m_rd = rv;
    end
    if (m_phase == PH_CAP) begin
      if (m_dv && !(re && a == 2'd0)) m_ov = 1;
      else if (re && a == 2'd1) m_ov = 0;
      m_dv = 1; m_cap = seen_s; m_cnt = m_cnt + 8'd1;
    end else begin
      if (re && a == 2'd0) m_dv = 0;
      if (re && a == 2'd1) m_ov = 0;
    end
    case (m_phase)
      PH_WAIT_HIGH: begin
        m_run = seen_b ? m_run + 1 : 0;
        if (m_run == D) begin m_phase = PH_CAP; m_run = 0; end
      end
      PH_CAP: m_phase = PH_WAIT_LOW;
      default: begin
        m_run = !seen_b ? m_run + 1 : 0;
        if (m_run == D) begin m_phase = PH_WAIT_HIGH; m_run = 0; end
      end
    endcase
  endfunction

  // Called at a negedge: drive, advance the model one edge, then check at the next negedge.
  task automatic tick(input logic re, input logic [1:0] a);
    logic [31:0] exp_rd;
    btn = b_cur; sw = s_cur; rd_en = re; rd_addr = a;
    model_edge(b_cur, s_cur, re, a);
    @(posedge clk);
    @(negedge clk);
    check("dv_model", {31'b0, data_valid}, {31'b0, m_dv});
    if (re) begin
      exp_rd = exp_q.pop_front();
      check("rd_model", rd_data, exp_rd);
    end else begin
      check("rd_hold", rd_data, m_rd);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 2'd0);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    tick(1'b1, a);
    d = rd_data;
  endtask

  task automatic press(input logic [23:0] s, input int hold, input int rel);
    s_cur = s; b_cur = 1'b1; idle(hold);
    b_cur = 1'b0; idle(rel);
  endtask

  task automatic wait_dv(input int budget, output int n);
    n = 0;
    while (!data_valid && n < budget) begin
      tick(1'b0, 2'd0);
      n++;
    end
    if (!data_valid) begin
      checks++; errors++;
      $display("FAIL dv_timeout actual=0 expected=1 within %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #0.5;
    model_reset();
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_dv", {31'b0, data_valid}, 32'h0);
    check("rst_state", {29'b0, dbg_state}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [23:0] sw;
    int          hold;
    logic [1:0]  addr;
    logic [31:0] exp_data;
    logic        exp_dv;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] d;
    int n;

    vecs[0] = '{24'h0100C3, 20, 2'd3, 32'h00000000, 1'b1};
    vecs[1] = '{24'h010086, 20, 2'd1, 32'h00000003, 1'b1};
    vecs[2] = '{24'h000000,  0, 2'd0, 32'h00010086, 1'b0};
    vecs[3] = '{24'h000000,  0, 2'd1, 32'h00000000, 1'b0};
    vecs[4] = '{24'h000000,  0, 2'd2, 32'h00000003, 1'b0};
    vecs[5] = '{24'hABCDEF,  9, 2'd0, 32'h00ABCDEF, 1'b0};
    vecs[6] = '{24'h123456,  7, 2'd2, 32'h00000004, 1'b0};
    vecs[7] = '{24'h000000,  0, 2'd0, 32'h00ABCDEF, 1'b0};

    b_cur = 0; s_cur = '0;
    btn = 0; sw = '0; rd_en = 0; rd_addr = '0;
    do_reset();

    // Short pulses never reach the debounce window.
    for (int p = 0; p < 4; p++) begin
      b_cur = 1'b1; idle(5);
      b_cur = 1'b0; idle(3);
    end
    idle(12);
    check("t2_dv", {31'b0, data_valid}, 32'h0);
    rd(2'd2, d);
    check("t2_press_cnt", d, 32'h0);

    // Press latency and data read.
    s_cur = 24'h070707; b_cur = 1'b1;
    wait_dv(30, n);
    check("t1_latency", n, D + 3);
    idle(25 - n);
    b_cur = 1'b0; idle(12);
    rd(2'd0, d);
    check("t1_data", d, 32'h00070707);
    check("t1_dv_clr", {31'b0, data_valid}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].hold > 0) press(vecs[i].sw, vecs[i].hold, 12);
      rd(vecs[i].addr, d);
      check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      check($sformatf("vec%0d_dv", i), {31'b0, data_valid}, {31'b0, vecs[i].exp_dv});
    end

    // Long hold followed by release bounces: exactly one capture.
    s_cur = 24'h5A5A5A; b_cur = 1'b1; idle(100);
    b_cur = 1'b0; idle(3); b_cur = 1'b1; idle(2);
    b_cur = 1'b0; idle(3); b_cur = 1'b1; idle(2);
    b_cur = 1'b0; idle(15);
    rd(2'd2, d);
    check("t4_press_cnt", d, 32'h5);
    rd(2'd0, d);
    check("t4_data", d, 32'h005A5A5A);

    // Data read on the capture edge returns the old word and leaves data_valid set.
    press(24'h111111, 12, 12);
    s_cur = 24'h222222; b_cur = 1'b1;
    idle(D + 2);
    rd(2'd0, d);
    check("t5_old_data", d, 32'h00111111);
    check("t5_dv_kept", {31'b0, data_valid}, 32'h1);
    idle(1);
    b_cur = 1'b0; idle(12);
    rd(2'd0, d);
    check("t5_new_data", d, 32'h00222222);
    rd(2'd1, d);
    check("t5_status", d, 32'h0);

    // Reset in the middle of a press debounce.
    press(24'h333333, 12, 12);
    rd(2'd2, d);
    check("t6_pre_cnt", d, 32'h8);
    b_cur = 1'b1; idle(5);
    do_reset();
    wait_dv(30, n);
    checks++;
    if (n < 9 || n > D + 3) begin
      errors++;
      $display("FAIL t6_recapture actual=%0d expected=9..%0d cycles", n, D + 3);
    end
    b_cur = 1'b0; idle(12);
    rd(2'd0, d);
    check("t6_data", d, 32'h00333333);
    rd(2'd2, d);
    check("t6_cnt", d, 32'h1);

    // Press counter wraps after 256 captures.
    b_cur = 1'b0; idle(2);
    do_reset();
    for (int p = 0; p < 255; p++) press(24'(p), 9, 10);
    rd(2'd2, d);
    check("t7_cnt_ff", d, 32'h000000FF);
    press(24'hFEDCBA, 9, 10);
    rd(2'd2, d);
    check("t7_cnt_wrap", d, 32'h0);

    // Random button levels, switch values and reads.
    for (int seg = 0; seg < 250; seg++) begin
      int len;
      b_cur = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 3) == 0) s_cur = 24'($urandom);
        if ($urandom_range(0, 9) < 3) tick(1'b1, 2'($urandom_range(0, 3)));
        else tick(1'b0, 2'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
